// File: rtl/vx_dispatch_pkg.sv
// Shared definitions for the dispatch demux: execution-unit channel indices,
// thread-index width helper and the default request bundle layout.
package vx_dispatch_pkg;

    localparam int EX_ALU = 0;
    localparam int EX_LSU = 1;
    localparam int EX_CSR = 2;
    localparam int EX_FPU = 3;
    localparam int EX_GPU = 4;
    localparam int NUM_EX = 5;

    // Width of a thread index; never narrower than one bit.
    function automatic int nt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_THREADS = 4;
    localparam int REQ_DATAW   = 256;

    typedef struct packed {
        logic [REQ_THREADS-1:0]          tmask;
        logic [nt_bits(REQ_THREADS)-1:0] tid;
        logic [REQ_DATAW-1:0]            data;
    } dispatch_req_t;

endpackage

// File: rtl/vx_dispatch_fifo.sv
// Single-channel FIFO, DEPTH entries (power of two, >= 2), no fall-through.
// Ports: clk, reset (async high), push_valid/push_ready/push_data,
// pop_valid/pop_ready/pop_data, count (occupancy, 0..DEPTH).
module vx_dispatch_fifo
    import vx_dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // A full FIFO refuses pushes even when it is popped the same cycle.
    assign push_ready = (cnt != CW'(DEPTH));
    assign pop_valid  = (cnt != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem[rp];
    assign count      = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end

endmodule

// File: rtl/vx_dispatch_demux.sv
// Routes one request per cycle to a per-unit FIFO selected by in_type and
// attaches the lowest active thread index. Ports: clk, reset, in_* request,
// out_* per-channel bundles; perf_* counters when VX_DISPATCH_PERF_EN is set.
module vx_dispatch_demux
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_CHANNELS = 5,
    parameter int TYPE_BITS    = 3,
    parameter int NUM_THREADS  = 4,
    parameter int DATAW        = 256,
    parameter int DEPTH        = 2,
    parameter logic [NUM_CHANNELS-1:0] CHANNEL_EN = '1,
    localparam int NT_BITS = nt_bits(NUM_THREADS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [TYPE_BITS-1:0]            in_type,
    input  logic [NUM_THREADS-1:0]          in_tmask,
    input  logic [DATAW-1:0]                in_data,
    output logic [NUM_CHANNELS-1:0]         out_valid,
    input  logic [NUM_CHANNELS-1:0]         out_ready,
    output logic [NUM_CHANNELS*DATAW-1:0]   out_data,
    output logic [NUM_CHANNELS*NUM_THREADS-1:0] out_tmask,
    output logic [NUM_CHANNELS*NT_BITS-1:0] out_tid
`ifdef VX_DISPATCH_PERF_EN
    ,
    output logic [NUM_CHANNELS*32-1:0]      perf_stall_cycles,
    output logic [NUM_CHANNELS*32-1:0]      perf_issued
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = NUM_THREADS + NT_BITS + DATAW;

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [NT_BITS-1:0]     tid;
        logic [DATAW-1:0]       data;
    } req_t;

    logic [NT_BITS-1:0]      tid;
    logic [NUM_CHANNELS-1:0] sel;
    logic [CW-1:0]           chan_count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] unused_push_ready;
    req_t                    in_req;

    // Scan from the top so the lowest set bit wins; zero mask gives 0.
    always_comb begin
        tid = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (in_tmask[i]) tid = NT_BITS'(i);
        end
    end

    assign in_req = '{tmask: in_tmask, tid: tid, data: in_data};

    // Out-of-range types are accepted and dropped; disabled channels stall.
    // in_valid is not an input here, which keeps the handshake loop-free.
    always_comb begin
        sel      = '0;
        in_ready = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (int'(in_type) == c) begin
                sel[c]   = 1'b1;
                in_ready = CHANNEL_EN[c] && (chan_count[c] != CW'(DEPTH));
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        if (CHANNEL_EN[c]) begin : g_fifo
            logic [RW-1:0] pop_bits;
            req_t          pop_req;

            vx_dispatch_fifo #(
                .WIDTH (RW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk        (clk),
                .reset      (reset),
                .push_valid (in_valid && sel[c]),
                .push_ready (unused_push_ready[c]),
                .push_data  (in_req),
                .pop_valid  (out_valid[c]),
                .pop_ready  (out_ready[c]),
                .pop_data   (pop_bits),
                .count      (chan_count[c])
            );

            assign pop_req = req_t'(pop_bits);
            assign out_data[c*DATAW +: DATAW]             = pop_req.data;
            assign out_tmask[c*NUM_THREADS +: NUM_THREADS] = pop_req.tmask;
            assign out_tid[c*NT_BITS +: NT_BITS]          = pop_req.tid;
        end else begin : g_off
            assign chan_count[c]           = '0;
            assign unused_push_ready[c]    = 1'b0;
            assign out_valid[c]            = 1'b0;
            assign out_data[c*DATAW +: DATAW]             = '0;
            assign out_tmask[c*NUM_THREADS +: NUM_THREADS] = '0;
            assign out_tid[c*NT_BITS +: NT_BITS]          = '0;
        end

`ifdef VX_DISPATCH_PERF_EN
        logic [31:0] stall_q;
        logic [31:0] issue_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stall_q <= '0;
                issue_q <= '0;
            end else begin
                if (in_valid && sel[c] && !in_ready) stall_q <= stall_q + 1'b1;
                if (in_valid && sel[c] && in_ready)  issue_q <= issue_q + 1'b1;
            end
        end

        assign perf_stall_cycles[c*32 +: 32] = stall_q;
        assign perf_issued[c*32 +: 32]       = issue_q;
`endif
    end

endmodule

// File: tb/tb_vx_dispatch_demux.sv
// Scoreboard bench for vx_dispatch_demux: directed pushes queue expected
// bundles, a negedge monitor pops and compares on every output handshake.
module tb_vx_dispatch_demux;
    import vx_dispatch_pkg::*;

    localparam int NCH = 5;
    localparam int NT  = 4;
    localparam int NTB = 2;
    localparam int DW  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_type;
    logic [NT-1:0]     in_tmask;
    logic [DW-1:0]     in_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    rdy;
    logic [NCH*DW-1:0] out_data;
    logic [NCH*NT-1:0] out_tmask;
    logic [NCH*NTB-1:0] out_tid;

    logic              dis_in_ready;
    logic [NCH-1:0]    dis_out_valid;
    logic [NCH*DW-1:0] dis_out_data;
    logic [NCH*NT-1:0] dis_out_tmask;
    logic [NCH*NTB-1:0] dis_out_tid;

`ifdef VX_DISPATCH_PERF_EN
    logic [NCH*32-1:0] perf_stall_cycles;
    logic [NCH*32-1:0] perf_issued;
    logic [NCH*32-1:0] dis_perf_stall_cycles;
    logic [NCH*32-1:0] dis_perf_issued;
`endif

    int errors = 0;
    int checks = 0;

    dispatch_req_t exp_q [NCH][$];

    always #5 clk = ~clk;

    vx_dispatch_demux dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_tmask  (in_tmask),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (rdy),
        .out_data  (out_data),
        .out_tmask (out_tmask),
        .out_tid   (out_tid)
`ifdef VX_DISPATCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_issued       (perf_issued)
`endif
    );

    vx_dispatch_demux #(.CHANNEL_EN(5'b10111)) dut_dis (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (1'b1),
        .in_ready  (dis_in_ready),
        .in_type   (3'd3),
        .in_tmask  (4'b0001),
        .in_data   ('0),
        .out_valid (dis_out_valid),
        .out_ready (5'b00000),
        .out_data  (dis_out_data),
        .out_tmask (dis_out_tmask),
        .out_tid   (dis_out_tid)
`ifdef VX_DISPATCH_PERF_EN
        ,
        .perf_stall_cycles (dis_perf_stall_cycles),
        .perf_issued       (dis_perf_issued)
`endif
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: out_ready only changes at posedge+1, so at negedge
    // out_valid && rdy predicts the pop at the next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                if (out_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid ch%0d: got valid expected idle", c);
                    end else if (rdy[c]) begin
                        dispatch_req_t e;
                        dispatch_req_t g;
                        e = exp_q[c].pop_front();
                        g.tmask = out_tmask[c*NT +: NT];
                        g.tid   = out_tid[c*NTB +: NTB];
                        g.data  = out_data[c*DW +: DW];
                        checks++;
                        if (g !== e) begin
                            errors++;
                            $display("FAIL pop ch%0d: got m=%b t=%0d d=%0h expected m=%b t=%0d d=%0h",
                                     c, g.tmask, g.tid, g.data, e.tmask, e.tid, e.data);
                        end
                    end
                end
            end
        end
    end

    // Entered and left at posedge+1; bounded wait for acceptance.
    task automatic send(input logic [2:0] t, input logic [NT-1:0] m,
                        input logic [NTB-1:0] tid_exp, input logic [DW-1:0] d);
        bit done = 0;
        in_valid = 1'b1;
        in_type  = t;
        in_tmask = m;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (t < NCH) exp_q[t].push_back('{tmask: m, tid: tid_exp, data: d});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout type=%0d: got no in_ready expected accept", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_type  = '0;
        in_tmask = '0;
        in_data  = '0;
        rdy      = '0;
        #3;
        check("reset_valid", 64'(out_valid), 64'h0);
        #9;
        reset = 1'b0;
        cycles(1);
        check("post_reset_valid", 64'(out_valid), 64'h0);
        check("post_reset_ready", 64'(in_ready), 64'h1);

        // Basic route
        send(3'd1, 4'b0100, 2'd2, 256'hA5);
        check("route_valid", 64'(out_valid), 64'h02);
        check("route_tid", 64'(out_tid[1*NTB +: NTB]), 64'h2);
        rdy[1] = 1'b1;
        cycles(2);
        check("route_drained", 64'(out_valid), 64'h0);
        rdy = '0;

        // Fill channel 0
        send(3'd0, 4'b0001, 2'd0, 256'hD0);
        send(3'd0, 4'b0011, 2'd0, 256'hD1);
        in_valid = 1'b1;
        in_type  = 3'd0;
        in_tmask = 4'b1000;
        in_data  = 256'hD2;
        @(negedge clk);
        check("full_ready", 64'(in_ready), 64'h0);
        cycles(1);
        rdy[0] = 1'b1;
        send(3'd0, 4'b1000, 2'd3, 256'hD2);
        cycles(3);
        check("fill_drained", 64'(out_valid), 64'h0);
        rdy = '0;

        // Independence
        send(3'd2, 4'b0010, 2'd1, 256'h20);
        send(3'd2, 4'b0110, 2'd1, 256'h21);
        send(3'd4, 4'b1100, 2'd2, 256'h40);
        check("indep_valid", 64'(out_valid), 64'h14);
        rdy[4] = 1'b1;
        cycles(2);
        check("indep_hold", 64'(out_valid), 64'h04);
        rdy[2] = 1'b1;
        cycles(3);
        check("indep_drained", 64'(out_valid), 64'h0);
        rdy = '0;

        // Simultaneous push/pop at count 1, zero tmask
        send(3'd0, 4'b1010, 2'd1, 256'h50);
        rdy[0] = 1'b1;
        send(3'd0, 4'b0000, 2'd0, 256'h51);
        check("pushpop_count1", 64'(out_valid[0]), 64'h1);
        cycles(1);
        check("pushpop_empty", 64'(out_valid[0]), 64'h0);
        rdy = '0;

        // NOP type
        in_valid = 1'b1;
        in_type  = 3'd7;
        in_data  = 256'h77;
        @(negedge clk);
        check("nop_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles(2);
        check("nop_no_valid", 64'(out_valid), 64'h0);

        // Disabled channel stalls permanently
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dis_ready", 64'(dis_in_ready), 64'h0);
        end
        cycles(1);

`ifdef VX_DISPATCH_PERF_EN
        send(3'd3, 4'b0001, 2'd0, 256'h30);
        send(3'd3, 4'b0001, 2'd0, 256'h31);
        in_valid = 1'b1;
        in_type  = 3'd3;
        in_tmask = 4'b0001;
        in_data  = 256'h32;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("perf_stall", 64'(perf_stall_cycles[3*32 +: 32]), 64'd3);
        check("perf_issued", 64'(perf_issued[3*32 +: 32]), 64'd2);
        rdy[3] = 1'b1;
        cycles(3);
        rdy = '0;
`endif

        // Reset mid-operation
        send(3'd1, 4'b0001, 2'd0, 256'h60);
        send(3'd1, 4'b0001, 2'd0, 256'h61);
        check("pre_reset_valid", 64'(out_valid), 64'h02);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'h0);
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        cycles(1);
        check("post_release_valid", 64'(out_valid), 64'h0);
        send(3'd0, 4'b1000, 2'd3, 256'h70);
        check("post_reset_latency", 64'(out_valid), 64'h01);
        rdy[0] = 1'b1;
        cycles(2);
        check("final_drained", 64'(out_valid), 64'h0);
        check("dis_no_valid", 64'(dis_out_valid), 64'h0);
        for (int c = 0; c < NCH; c++) begin
            check("queue_empty", 64'(exp_q[c].size()), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
